// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity type
// encoding and the 3-input majority helper used by the bit sampler.
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_e;

  typedef enum logic {
    ParEven = 1'b0,
    ParOdd  = 1'b1
  } par_typ_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit sampler for the UART receiver: counts oversampling edges within a bit and
// majority-votes the three samples around mid-bit.
//   clk_i          receive clock (PRESCALE x baud)
//   rst_i          synchronous reset, active-high
//   en_i           count while a frame is in progress; counter held at 0 otherwise
//   rx_i           synchronised serial line
//   sampled_bit_o  majority of the three mid-bit samples (valid with sample_done_o)
//   sample_done_o  high on the cycle the third sample is taken
//   bit_end_o      high on the last edge of the bit period
module uart_rx_sampler
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned PRESCALE = 8,
  parameter int unsigned CNT_W    = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic rx_i,
  output logic sampled_bit_o,
  output logic sample_done_o,
  output logic bit_end_o
);

  localparam logic [CNT_W-1:0] SmpA     = CNT_W'(PRESCALE / 2 - 1);
  localparam logic [CNT_W-1:0] SmpB     = CNT_W'(PRESCALE / 2);
  localparam logic [CNT_W-1:0] SmpC     = CNT_W'(PRESCALE / 2 + 1);
  localparam logic [CNT_W-1:0] LastEdge = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             smp_a_q, smp_a_d;
  logic             smp_b_q, smp_b_d;

  always_comb begin
    cnt_d   = cnt_q;
    smp_a_d = smp_a_q;
    smp_b_d = smp_b_q;
    if (!en_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == LastEdge) ? '0 : cnt_q + 1'b1;
      if (cnt_q == SmpA) smp_a_d = rx_i;
      if (cnt_q == SmpB) smp_b_d = rx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      smp_a_q <= 1'b1;
      smp_b_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      smp_a_q <= smp_a_d;
      smp_b_q <= smp_b_d;
    end
  end

  // Third sample is taken live from rx_i so the vote is ready on the same cycle.
  assign sampled_bit_o = maj3(smp_a_q, smp_b_q, rx_i);
  assign sample_done_o = en_i && (cnt_q == SmpC);
  assign bit_end_o     = en_i && (cnt_q == LastEdge);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: synchronises RX_IN, frames start/data/[parity]/stop bits,
// checks parity and stop, and presents the received byte with one-cycle status pulses.
//   CLK         receive clock (PRESCALE x baud)
//   RST_SYN     synchronous reset, active-high
//   RX_IN       serial line, idle high, asynchronous to CLK
//   PAR_EN      frame carries a parity bit (latched at start detect)
//   PAR_TYP     0 = even, 1 = odd parity (latched at start detect)
//   P_DATA      last cleanly received byte
//   Data_Valid  pulse: P_DATA updated from a clean frame
//   PAR_ERR     pulse: parity mismatch
//   STP_ERR     pulse: stop bit sampled low
//   busy        frame in progress
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PRESCALE  = 8,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                 CLK,
  input  logic                 RST_SYN,
  input  logic                 RX_IN,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  output logic [DATA_BITS-1:0] P_DATA,
  output logic                 Data_Valid,
  output logic                 PAR_ERR,
  output logic                 STP_ERR,
  output logic                 busy
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS);

  rx_state_e            state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shadow_q, shadow_d;
  logic [DATA_BITS-1:0] p_data_q, p_data_d;
  logic                 perr_q, perr_d;
  logic                 par_en_q, par_en_d;
  par_typ_e             par_typ_q, par_typ_d;
  logic                 dv_q, dv_d;
  logic                 par_err_q, par_err_d;
  logic                 stp_err_q, stp_err_d;
  logic                 active;
  logic                 sampled_bit, sample_done, bit_end;
  logic                 exp_par;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE),
    .CNT_W   (CNT_W)
  ) u_sampler (
    .clk_i        (CLK),
    .rst_i        (RST_SYN),
    .en_i         (active),
    .rx_i         (rx_s_q),
    .sampled_bit_o(sampled_bit),
    .sample_done_o(sample_done),
    .bit_end_o    (bit_end)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST_SYN) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!rx_s_q) state_d = StStart;
      StStart: begin
        if (sample_done && sampled_bit) state_d = StIdle;
        else if (bit_end)               state_d = StData;
      end
      StData: begin
        if (bit_end && (bit_cnt_q == LastBit)) state_d = par_en_q ? StParity : StStop;
      end
      StParity: if (bit_end) state_d = StStop;
      // Leave mid stop bit so the next start edge is caught even with baud skew.
      StStop:   if (sample_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    active = (state_q != StIdle);
    busy   = active;
  end

  assign exp_par = (par_typ_q == ParOdd) ? ~^shadow_q : ^shadow_q;

  // Datapath next-state.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    p_data_d  = p_data_q;
    perr_d    = perr_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    dv_d      = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          par_en_d  = PAR_EN;
          par_typ_d = par_typ_e'(PAR_TYP);
        end
      end
      StData: begin
        if (sample_done) begin
          shadow_d  = {sampled_bit, shadow_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StParity: if (sample_done) perr_d = (sampled_bit != exp_par);
      StStop: begin
        if (sample_done) begin
          if (sampled_bit && !perr_q) begin
            p_data_d = shadow_q;
            dv_d     = 1'b1;
          end
          stp_err_d = ~sampled_bit;
          par_err_d = perr_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_SYN) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      bit_cnt_q <= '0;
      shadow_q  <= '0;
      p_data_q  <= '0;
      perr_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= ParEven;
      dv_q      <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
      p_data_q  <= p_data_d;
      perr_q    <= perr_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      dv_q      <= dv_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: drives serial frames, pushes expected receive events
// into a scoreboard queue and compares them against events captured from the DUT.
module tb_uart_rx_core;

  localparam int unsigned PRESCALE = 8;

  typedef struct packed {
    logic       dv;
    logic       perr;
    logic       serr;
    logic [7:0] data;
  } ev_t;

  logic       CLK;
  logic       RST_SYN;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  uart_rx_core #(
    .DATA_BITS(8),
    .PRESCALE (PRESCALE),
    .CNT_W    (3)
  ) dut (
    .CLK       (CLK),
    .RST_SYN   (RST_SYN),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Capture every cycle carrying a status pulse; a stretched pulse shows up twice.
  always @(negedge CLK) begin
    if (Data_Valid || PAR_ERR || STP_ERR) begin
      ev_t ev;
      ev = {Data_Valid, PAR_ERR, STP_ERR, P_DATA};
      obs_q.push_back(ev);
    end
  end

  function automatic ev_t mk(input logic dv, input logic pe, input logic se,
                             input logic [7:0] d);
    ev_t e;
    e = {dv, pe, se, d};
    return e;
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("dv=%0b perr=%0b serr=%0b data=%h", e.dv, e.perr, e.serr, e.data);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    RX_IN = b;
    if (glitch) begin
      tick(5);
      RX_IN = ~b;
      tick(1);
      RX_IN = b;
      tick(2);
    end else begin
      tick(PRESCALE);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par_bit,
                            input logic stop_bit, input int glitch_idx);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], i == glitch_idx);
    if (has_par) drive_bit(par_bit, 1'b0);
    drive_bit(stop_bit, 1'b0);
    RX_IN = 1'b1;
  endtask

  task automatic get_obs(input string name, output ev_t o, output bit ok);
    ok = 1'b0;
    o  = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (obs_q.size() > 0) begin
        o  = obs_q.pop_front();
        ok = 1'b1;
      end else begin
        tick(1);
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no receive event within 200 cycles, required one", name);
    end
  endtask

  task automatic test_reset();
    RST_SYN = 1'b1;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    tick(3);
    n_cmp++;
    if ({P_DATA, Data_Valid, PAR_ERR, STP_ERR, busy} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got P_DATA=%h dv=%0b perr=%0b serr=%0b busy=%0b, required all 0",
               P_DATA, Data_Valid, PAR_ERR, STP_ERR, busy);
    end
    RST_SYN = 1'b0;
    tick(4);
  endtask

  task automatic test_no_parity();
    ev_t o, e;
    bit  ok;
    PAR_EN = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'hD9));
    send_frame(8'hD9, 1'b0, 1'b0, 1'b1, -1);
    get_obs("nopar_frame", o, ok);
    e = exp_q.pop_front();
    if (ok) begin
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL nopar_frame: got %s, required %s", fmt(o), fmt(e));
      end
    end
    tick(3);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL nopar_busy_drop: got busy=%0b, required 0", busy);
    end
    tick(10);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL nopar_single_pulse: got %0d extra events, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    ev_t o, e;
    bit  ok;
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'hD9));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'hD9));
    send_frame(8'hD9, 1'b1, 1'b1, 1'b1, -1);
    PAR_TYP = 1'b1;
    send_frame(8'hD9, 1'b1, 1'b0, 1'b1, -1);
    for (int k = 0; k < 2; k++) begin
      get_obs($sformatf("b2b_frame%0d", k), o, ok);
      e = exp_q.pop_front();
      if (ok) begin
        n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL b2b_frame%0d: got %s, required %s", k, fmt(o), fmt(e));
        end
      end
    end
    tick(12);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_extra: got %0d extra events, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_parity_error();
    ev_t o, e;
    bit  ok;
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'hD9));
    send_frame(8'hD9, 1'b1, 1'b0, 1'b1, -1);
    get_obs("par_err", o, ok);
    e = exp_q.pop_front();
    if (ok) begin
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL par_err: got %s, required %s", fmt(o), fmt(e));
      end
    end
    PAR_EN = 1'b0;
    tick(12);
  endtask

  task automatic test_stop_error();
    ev_t o, e;
    bit  ok;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'hD9));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'hA5));
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    tick(16);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    for (int k = 0; k < 2; k++) begin
      get_obs($sformatf("stp_seq%0d", k), o, ok);
      e = exp_q.pop_front();
      if (ok) begin
        n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL stp_seq%0d: got %s, required %s", k, fmt(o), fmt(e));
        end
      end
    end
    tick(12);
  endtask

  task automatic test_glitch();
    ev_t o, e;
    bit  ok;
    RX_IN = 1'b0;
    tick(2);
    RX_IN = 1'b1;
    tick(16);
    n_cmp++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_glitch: got events=%0d busy=%0b, required events=0 busy=0",
               obs_q.size(), busy);
      obs_q.delete();
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h6B));
    send_frame(8'h6B, 1'b0, 1'b0, 1'b1, 2);
    get_obs("data_glitch", o, ok);
    e = exp_q.pop_front();
    if (ok) begin
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL data_glitch: got %s, required %s", fmt(o), fmt(e));
      end
    end
    tick(12);
  endtask

  task automatic test_mid_reset();
    ev_t o, e;
    bit  ok;
    logic [7:0] ff_byte;
    ff_byte = 8'hFF;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(ff_byte[i], 1'b0);
    RX_IN = 1'b1;
    tick(3);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midframe_busy: got busy=%0b, required 1", busy);
    end
    RST_SYN = 1'b1;
    tick(1);
    n_cmp++;
    if ({P_DATA, Data_Valid, PAR_ERR, STP_ERR, busy} !== 12'h000) begin
      n_bad++;
      $display("FAIL midframe_reset: got P_DATA=%h dv=%0b perr=%0b serr=%0b busy=%0b, required all 0",
               P_DATA, Data_Valid, PAR_ERR, STP_ERR, busy);
    end
    RST_SYN = 1'b0;
    tick(40);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_no_pulse: got %0d events, required 0", obs_q.size());
      obs_q.delete();
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h3C));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    get_obs("after_reset", o, ok);
    e = exp_q.pop_front();
    if (ok) begin
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL after_reset: got %s, required %s", fmt(o), fmt(e));
      end
    end
    tick(12);
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_back_to_back();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_mid_reset();
    n_cmp++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got obs=%0d exp=%0d left, required 0/0",
               obs_q.size(), exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
